bus_arb4: RTL and testbench

//   Round-robin arbiter producing the one-hot select that drives the 32-bit 4:1 one-hot mux
//   (sel[0]->src1 .. sel[3]->src4) in front of a shared downstream port (e.g. memory bus).

---
 rtl/bus_arb4_pkg.sv | 19 +
 rtl/bus_arb4_rr_pick4.sv | 31 +++
 rtl/bus_arb4.sv | 152 +++++++++++++++
 tb/tb_bus_arb4.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bus_arb4_pkg.sv
// Shared definitions for the bus_arb4 round-robin arbiter.
//   arb_state_e : FSM encoding (ARB_IDLE = 0, ARB_GRANT = 1)
//   NREQ_DEF    : default requester count (the downstream one-hot mux is 4:1)
//   oh2idx()    : one-hot grant to 2-bit index
package bus_arb4_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF = 4;

    // Grant is guaranteed one-hot or zero, so an OR-encode is exact.
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        oh2idx = {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/bus_arb4_rr_pick4.sv
// Combinational rotating-priority picker (rr_pick4).
//   req    in  [3:0] candidate requests
//   ptr    in  [1:0] index of the highest-priority requester
//   onehot out [3:0] first set bit scanning ptr, ptr+1, .. mod 4
//   any    out       |req
module bus_arb4_rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] onehot,
    output logic       any
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_arb4.sv
// bus_arb4: round-robin arbiter generating the one-hot select for a 4:1 AND-OR
// mux in front of a shared downstream port.
//   clk, resetn : clock, async active-low reset
//   req         : per-source request, held until its ack
//   lock        : per-source burst lock (only when ARB_LOCK_EN is defined)
//   gnt         : registered one-hot grant (mux select)
//   out_valid   : registered, == |gnt
//   out_ready   : downstream accept
//   ack         : gnt during the handshake cycle, else 0
//   busy        : registered, state == GRANT
// Optional feature macro: ARB_LOCK_EN (adds lock port, LOCK_MAX and lock_cnt).
module bus_arb4
    import bus_arb4_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
`ifdef ARB_LOCK_EN
    , parameter int LOCK_MAX = 16
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0] lock,
`endif
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NREQ-1:0] ack,
    output logic            busy
);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            hs;
    logic [1:0]      rot_ptr;
    logic [NREQ-1:0] pick_req;
    logic [1:0]      pick_ptr;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic            lock_hold;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    assign hs      = out_valid_q & out_ready;
    // Rotation target: one past the current winner, 2-bit wrap (3 -> 0).
    assign rot_ptr = oh2idx(gnt_q) + 2'd1;

    // One picker serves both cases: fresh arbitration from IDLE, and
    // re-arbitration during a handshake excluding the current holder
    // (its req is still high in the ack cycle).
    assign pick_req = (state_q == ARB_IDLE) ? req : (req & ~gnt_q);
    assign pick_ptr = (state_q == ARB_IDLE) ? ptr_q : rot_ptr;

    bus_arb4_rr_pick4 u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .any    (pick_any)
    );

`ifdef ARB_LOCK_EN
    // Hold the grant while the holder asks for lock, until the burst limit.
    assign lock_hold = |(gnt_q & lock & req) && (lock_cnt_q != LCW'(LOCK_MAX - 1));
`else
    assign lock_hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_oh;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Grant is frozen until the consumer accepts; no preemption.
                if (hs) begin
                    if (lock_hold) begin
`ifdef ARB_LOCK_EN
                        lock_cnt_d = lock_cnt_q + LCW'(1);
`endif
                    end else begin
                        ptr_d = rot_ptr;
`ifdef ARB_LOCK_EN
                        lock_cnt_d = '0;
`endif
                        if (pick_any) begin
                            gnt_d = pick_oh;
                        end else begin
                            gnt_d   = '0;
                            state_d = ARB_IDLE;
                        end
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
        out_valid_d = |gnt_d;
        busy_d      = (state_d == ARB_GRANT);
    end

    // Outputs
    always_comb begin
        gnt       = gnt_q;
        out_valid = out_valid_q;
        busy      = busy_q;
        ack       = hs ? gnt_q : '0;
    end

endmodule

// File: tb/tb_bus_arb4.sv
// Directed scoreboard bench for bus_arb4. Each cycle the expected grant/ack
// is pushed when inputs are driven and popped when outputs are sampled,
// mid low-phase of the clock.
module tb_bus_arb4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = '0;
    logic       out_ready = 1'b0;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] ack;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] a;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef ARB_LOCK_EN
    logic [3:0] lock = '0;
    bus_arb4 #(.NREQ(4), .LOCK_MAX(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .lock(lock),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .ack(ack), .busy(busy));
`else
    bus_arb4 #(.NREQ(4)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .ack(ack), .busy(busy));
`endif

    // Drive one cycle's inputs, push the expected outputs for the current
    // (pre-edge) cycle, then pop and compare shortly after.
    task automatic cyc(input string tag, input logic rn, input logic [3:0] r,
                       input logic rdy, input logic [3:0] eg, input logic [3:0] ea);
        exp_t e;
        @(negedge clk);
        resetn    = rn;
        req       = r;
        out_ready = rdy;
        sb.push_back('{g: eg, a: ea});
        #2;
        e = sb.pop_front();
        n_cmp++;
        assert (gnt === e.g) else begin
            n_mis++;
            $error("FAIL %s.gnt observed=%b expected=%b", tag, gnt, e.g);
        end
        n_cmp++;
        assert (ack === e.a) else begin
            n_mis++;
            $error("FAIL %s.ack observed=%b expected=%b", tag, ack, e.a);
        end
        n_cmp++;
        assert (out_valid === (|e.g)) else begin
            n_mis++;
            $error("FAIL %s.out_valid observed=%b expected=%b", tag, out_valid, |e.g);
        end
        n_cmp++;
        assert (busy === (|e.g)) else begin
            n_mis++;
            $error("FAIL %s.busy observed=%b expected=%b", tag, busy, |e.g);
        end
        // Protocol: a granted requester keeps req high until acked.
        n_cmp++;
        assert ((gnt & ~req) === 4'b0000) else begin
            n_mis++;
            $error("FAIL %s.req_hold gnt=%b req=%b", tag, gnt, req);
        end
    endtask

    initial begin
        // Reset state
        cyc("rst",  1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        cyc("rst2", 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000);

        // 1: single request, 1-cycle latency, ack then idle
        cyc("t1a", 1'b1, 4'b0100, 1'b1, 4'b0000, 4'b0000);
        cyc("t1b", 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0100);
        cyc("t1c", 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000);

        // 2: all requesting from ptr 0, back-to-back rotation with no gaps
        cyc("t2r", 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        cyc("t2a", 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000);
        cyc("t2b", 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0001);
        cyc("t2c", 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0010);
        cyc("t2d", 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100);
        cyc("t2e", 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b1000);
        cyc("t2f", 1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001);
        cyc("t2g", 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000);

        // 3: stall holds grant, late req[3] does not preempt (ptr is 1 here)
        cyc("t3a", 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000);
        cyc("t3b", 1'b1, 4'b0010, 1'b0, 4'b0010, 4'b0000);
        cyc("t3c", 1'b1, 4'b0010, 1'b0, 4'b0010, 4'b0000);
        cyc("t3d", 1'b1, 4'b1010, 1'b0, 4'b0010, 4'b0000);
        cyc("t3e", 1'b1, 4'b1010, 1'b0, 4'b0010, 4'b0000);
        cyc("t3f", 1'b1, 4'b1010, 1'b0, 4'b0010, 4'b0000);
        cyc("t3g", 1'b1, 4'b1010, 1'b1, 4'b0010, 4'b0010);

        // 5: winner 3 acked while req[0] present -> ptr wraps, gnt 0001
        cyc("t5a", 1'b1, 4'b1001, 1'b1, 4'b1000, 4'b1000);
        cyc("t5b", 1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001);
        cyc("t5c", 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000);

        // 4: async reset mid-transfer drops grant at once, no ack
        cyc("t4a", 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0000);
        cyc("t4b", 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000);
        cyc("t4c", 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000);
        cyc("t4d", 1'b1, 4'b1010, 1'b0, 4'b0000, 4'b0000);
        cyc("t4e", 1'b1, 4'b1010, 1'b0, 4'b0010, 4'b0000);
        cyc("t4f", 1'b1, 4'b1010, 1'b1, 4'b0010, 4'b0010);
        cyc("t4g", 1'b1, 4'b1000, 1'b1, 4'b1000, 4'b1000);
        cyc("t4h", 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000);

`ifdef ARB_LOCK_EN
        // 6: lock burst of LOCK_MAX transfers on source 0, then rotation
        cyc("t6r", 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        lock = 4'b0001;
        cyc("t6a", 1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000);
        cyc("t6b", 1'b1, 4'b0011, 1'b1, 4'b0001, 4'b0001);
        cyc("t6c", 1'b1, 4'b0011, 1'b1, 4'b0001, 4'b0001);
        cyc("t6d", 1'b1, 4'b0011, 1'b1, 4'b0001, 4'b0001);
        cyc("t6e", 1'b1, 4'b0011, 1'b1, 4'b0001, 4'b0001);
        lock = 4'b0000;
        cyc("t6f", 1'b1, 4'b0010, 1'b1, 4'b0010, 4'b0010);
        cyc("t6g", 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
